// File: rtl/riscv_multicycle_ctrl_if.sv
// Control interface between the multicycle control FSM and the RV64I datapath.
// Zero latency: plain wires bundled for port grouping.
// No backpressure: the datapath acts on every command in the cycle it is driven.
//
// Signals: opcode/funct3/funct7_5/z flow from datapath to control; every
// enable, mux select, ALU selector, exitState and state_out flow the other way.
// The master modport is the control FSM side; the slave modport is the datapath.
interface riscv_multicycle_ctrl_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       z;

    logic       PCwrite;
    logic       PCSource;
    logic       IRwrite;
    logic       RegWrite;
    logic       loadRegA;
    logic       loadRegB;
    logic       loadRegAluOut;
    logic       loadRegMemData;
    logic       MemData_Write;
    logic       SelMux2;
    logic [1:0] SelMux4;
    logic       SelMuxMem;
    logic [2:0] AluOperation;
    logic       exitState;
    logic [3:0] state_out;

    modport master (
        input  opcode, funct3, funct7_5, z,
        output PCwrite, PCSource, IRwrite, RegWrite, loadRegA, loadRegB,
               loadRegAluOut, loadRegMemData, MemData_Write, SelMux2, SelMux4,
               SelMuxMem, AluOperation, exitState, state_out
    );

    modport slave (
        output opcode, funct3, funct7_5, z,
        input  PCwrite, PCSource, IRwrite, RegWrite, loadRegA, loadRegB,
               loadRegAluOut, loadRegMemData, MemData_Write, SelMux2, SelMux4,
               SelMuxMem, AluOperation, exitState, state_out
    );
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle control FSM for the RV64I-subset datapath (add/sub/and/xor, addi/andi/xori, ld, sd, beq, bne).
// Latency: 4 (branch taken) to 8 (ld) cycles per instruction, FETCH to FETCH.
// No backpressure: memory is fixed-latency, the FSM advances every cycle.
//
// Ports: clk, rst (synchronous, active-high); ctl is the master side of the
// datapath control interface (IR fields and ALU zero in, enables/selects out).
// Outputs decode the current state (plus z in BRANCH) and are held at 0 while rst=1.
module riscv_multicycle_ctrl #(
    parameter logic [2:0] ALU_ADD = 3'b001,
    parameter logic [2:0] ALU_SUB = 3'b010,
    parameter logic [2:0] ALU_AND = 3'b011,
    parameter logic [2:0] ALU_XOR = 3'b100
) (
    input  logic                          clk,
    input  logic                          rst,
    riscv_multicycle_ctrl_if.master       ctl
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        FETCH_IR = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        LD_WAIT  = 4'd4,
        LD_MDR   = 4'd5,
        LD_WB    = 4'd6,
        SD_WRITE = 4'd7,
        R_EXEC   = 4'd8,
        I_EXEC   = 4'd9,
        ALU_WB   = 4'd10,
        BRANCH   = 4'd11,
        PC_INC   = 4'd12,
        HALT     = 4'd13
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_e state_q, state_d;

    logic r_legal, i_legal, taken, is_load;
    logic [2:0] r_alu, i_alu;

    // Funct decode, shared by DECODE (legality) and the EXEC states (selector).
    // The IR is stable for the whole instruction, so reading it late is safe.
    always_comb begin
        r_legal = (ctl.funct3 == 3'b000) || (ctl.funct3 == 3'b111) || (ctl.funct3 == 3'b100);
        i_legal = r_legal;
        is_load = (ctl.opcode == OP_LOAD);
        taken   = ((ctl.funct3 == 3'b000) &&  ctl.z) ||
                  ((ctl.funct3 == 3'b001) && !ctl.z);
        unique case (ctl.funct3)
            3'b111:  r_alu = ALU_AND;
            3'b100:  r_alu = ALU_XOR;
            default: r_alu = ctl.funct7_5 ? ALU_SUB : ALU_ADD;
        endcase
        unique case (ctl.funct3)
            3'b111:  i_alu = ALU_AND;
            3'b100:  i_alu = ALU_XOR;
            default: i_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d            = state_q;
        ctl.PCwrite        = 1'b0;
        ctl.PCSource       = 1'b0;
        ctl.IRwrite        = 1'b0;
        ctl.RegWrite       = 1'b0;
        ctl.loadRegA       = 1'b0;
        ctl.loadRegB       = 1'b0;
        ctl.loadRegAluOut  = 1'b0;
        ctl.loadRegMemData = 1'b0;
        ctl.MemData_Write  = 1'b0;
        ctl.SelMux2        = 1'b0;
        ctl.SelMux4        = 2'b00;
        ctl.SelMuxMem      = 1'b0;
        ctl.AluOperation   = 3'b000;
        ctl.exitState      = 1'b0;

        case (state_q)
            FETCH:    state_d = FETCH_IR;
            FETCH_IR: begin
                ctl.IRwrite = 1'b1;
                state_d     = DECODE;
            end
            DECODE: begin
                // Precompute branch target PC + (imm << 1) into AluOut.
                ctl.loadRegA      = 1'b1;
                ctl.loadRegB      = 1'b1;
                ctl.SelMux4       = 2'b11;
                ctl.AluOperation  = ALU_ADD;
                ctl.loadRegAluOut = 1'b1;
                if (ctl.opcode == OP_R && r_legal)
                    state_d = R_EXEC;
                else if (ctl.opcode == OP_I && i_legal)
                    state_d = I_EXEC;
                else if ((ctl.opcode == OP_LOAD || ctl.opcode == OP_STORE) && ctl.funct3 == 3'b011)
                    state_d = MEM_ADDR;
                else if (ctl.opcode == OP_BRANCH && ctl.funct3[2:1] == 2'b00)
                    state_d = BRANCH;
                else
                    state_d = HALT;
            end
            MEM_ADDR: begin
                ctl.SelMux2       = 1'b1;
                ctl.SelMux4       = 2'b10;
                ctl.AluOperation  = ALU_ADD;
                ctl.loadRegAluOut = 1'b1;
                state_d           = is_load ? LD_WAIT : SD_WRITE;
            end
            LD_WAIT:  state_d = LD_MDR;
            LD_MDR: begin
                ctl.loadRegMemData = 1'b1;
                state_d            = LD_WB;
            end
            LD_WB: begin
                ctl.RegWrite  = 1'b1;
                ctl.SelMuxMem = 1'b1;
                state_d       = PC_INC;
            end
            SD_WRITE: begin
                ctl.MemData_Write = 1'b1;
                state_d           = PC_INC;
            end
            R_EXEC: begin
                ctl.SelMux2       = 1'b1;
                ctl.SelMux4       = 2'b00;
                ctl.AluOperation  = r_alu;
                ctl.loadRegAluOut = 1'b1;
                state_d           = ALU_WB;
            end
            I_EXEC: begin
                ctl.SelMux2       = 1'b1;
                ctl.SelMux4       = 2'b10;
                ctl.AluOperation  = i_alu;
                ctl.loadRegAluOut = 1'b1;
                state_d           = ALU_WB;
            end
            ALU_WB: begin
                ctl.RegWrite = 1'b1;
                state_d      = PC_INC;
            end
            BRANCH: begin
                // ALU compares A-B for z; AluOut keeps the DECODE target.
                ctl.SelMux2      = 1'b1;
                ctl.SelMux4      = 2'b00;
                ctl.AluOperation = ALU_SUB;
                ctl.PCwrite      = taken;
                ctl.PCSource     = taken;
                state_d          = taken ? FETCH : PC_INC;
            end
            PC_INC: begin
                ctl.SelMux4      = 2'b01;
                ctl.AluOperation = ALU_ADD;
                ctl.PCwrite      = 1'b1;
                state_d          = FETCH;
            end
            HALT: begin
                ctl.exitState = 1'b1;
                state_d       = HALT;
            end
            default:  state_d = HALT;
        endcase

        // Mask every command while reset is high so the reset edge writes nothing.
        if (rst) begin
            ctl.PCwrite        = 1'b0;
            ctl.PCSource       = 1'b0;
            ctl.IRwrite        = 1'b0;
            ctl.RegWrite       = 1'b0;
            ctl.loadRegA       = 1'b0;
            ctl.loadRegB       = 1'b0;
            ctl.loadRegAluOut  = 1'b0;
            ctl.loadRegMemData = 1'b0;
            ctl.MemData_Write  = 1'b0;
            ctl.SelMux2        = 1'b0;
            ctl.SelMux4        = 2'b00;
            ctl.SelMuxMem      = 1'b0;
            ctl.AluOperation   = 3'b000;
            ctl.exitState      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    assign ctl.state_out = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for the multicycle control FSM: per-cycle state and control-word checks
// for each instruction class, illegal encodings into HALT, and reset abandoning a store.
module tb_riscv_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_vec  = 0;
    int   n_miss = 0;

    riscv_multicycle_ctrl_if bus();

    riscv_multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, pcs, irw, rw, la, lb, lao, lmd, mw, s2;
        logic [1:0] s4;
        logic       smem;
        logic [2:0] alu;
        logic       ex;
    } ctl_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cur_ctl();
        ctl_t c;
        c.pcw  = bus.PCwrite;        c.pcs = bus.PCSource;    c.irw  = bus.IRwrite;
        c.rw   = bus.RegWrite;       c.la  = bus.loadRegA;    c.lb   = bus.loadRegB;
        c.lao  = bus.loadRegAluOut;  c.lmd = bus.loadRegMemData;
        c.mw   = bus.MemData_Write;  c.s2  = bus.SelMux2;     c.s4   = bus.SelMux4;
        c.smem = bus.SelMuxMem;      c.alu = bus.AluOperation; c.ex  = bus.exitState;
        return {15'd0, c};
    endfunction

    // Hand-written per-state control table.
    function automatic logic [31:0] exp_ctl(input logic [3:0] st, input logic [2:0] xalu, input logic taken);
        ctl_t c;
        c = '0;
        case (st)
            4'd1:  c.irw = 1'b1;
            4'd2:  begin c.la = 1'b1; c.lb = 1'b1; c.lao = 1'b1; c.s4 = 2'b11; c.alu = 3'b001; end
            4'd3:  begin c.s2 = 1'b1; c.s4 = 2'b10; c.alu = 3'b001; c.lao = 1'b1; end
            4'd5:  c.lmd = 1'b1;
            4'd6:  begin c.rw = 1'b1; c.smem = 1'b1; end
            4'd7:  c.mw = 1'b1;
            4'd8:  begin c.s2 = 1'b1; c.s4 = 2'b00; c.lao = 1'b1; c.alu = xalu; end
            4'd9:  begin c.s2 = 1'b1; c.s4 = 2'b10; c.lao = 1'b1; c.alu = xalu; end
            4'd10: c.rw = 1'b1;
            4'd11: begin c.s2 = 1'b1; c.alu = 3'b010; c.pcw = taken; c.pcs = taken; end
            4'd12: begin c.s4 = 2'b01; c.alu = 3'b001; c.pcw = 1'b1; end
            4'd13: c.ex = 1'b1;
            default: c = '0;
        endcase
        return {15'd0, c};
    endfunction

    task automatic set_ir(input logic [6:0] opc, input logic [2:0] f3, input logic f75, input logic zz);
        bus.opcode   = opc;
        bus.funct3   = f3;
        bus.funct7_5 = f75;
        bus.z        = zz;
    endtask

    // Called in FETCH, low clock phase; seq lists the states, first in the low nibble.
    task automatic run_instr(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                             input logic f75, input logic zz, input logic [31:0] seq,
                             input int n, input logic [2:0] xalu, input logic taken);
        logic [3:0] st;
        set_ir(opc, f3, f75, zz);
        #1;
        for (int i = 0; i < n; i++) begin
            st = seq[4*i +: 4];
            chk({tag, "_st"}, {28'd0, bus.state_out}, {28'd0, st});
            chk({tag, "_ctl"}, cur_ctl(), exp_ctl(st, xalu, taken));
            @(negedge clk); #1;
        end
        chk({tag, "_end"}, {28'd0, bus.state_out}, 32'd0);
    endtask

    task automatic run_halt(input string tag, input logic [6:0] opc, input logic [2:0] f3, input logic f75);
        set_ir(opc, f3, f75, 1'b0);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_pre"}, {28'd0, bus.state_out}, i);
            @(negedge clk); #1;
        end
        for (int i = 0; i < 20; i++) begin
            chk({tag, "_st"}, {28'd0, bus.state_out}, 32'd13);
            chk({tag, "_ctl"}, cur_ctl(), exp_ctl(4'd13, 3'b000, 1'b0));
            @(negedge clk); #1;
        end
        rst = 1'b1; #1;
        chk({tag, "_rstctl"}, cur_ctl(), 32'd0);
        @(negedge clk); #1;
        rst = 1'b0; #1;
        chk({tag, "_rstst"}, {28'd0, bus.state_out}, 32'd0);
        chk({tag, "_rstout"}, cur_ctl(), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        set_ir(7'd0, 3'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_ctl", cur_ctl(), 32'd0);
        chk("rst_st", {28'd0, bus.state_out}, 32'd0);
        rst = 1'b0; #1;
        chk("post_rst_ctl", cur_ctl(), 32'd0);
        chk("post_rst_st", {28'd0, bus.state_out}, 32'd0);

        run_instr("add",   7'b0110011, 3'b000, 1'b0, 1'b0, 32'h00CA8210, 6, 3'b001, 1'b0);
        run_instr("sub",   7'b0110011, 3'b000, 1'b1, 1'b0, 32'h00CA8210, 6, 3'b010, 1'b0);
        run_instr("and",   7'b0110011, 3'b111, 1'b0, 1'b0, 32'h00CA8210, 6, 3'b011, 1'b0);
        run_instr("xor",   7'b0110011, 3'b100, 1'b0, 1'b0, 32'h00CA8210, 6, 3'b100, 1'b0);
        run_instr("addi",  7'b0010011, 3'b000, 1'b0, 1'b0, 32'h00CA9210, 6, 3'b001, 1'b0);
        run_instr("xori",  7'b0010011, 3'b100, 1'b0, 1'b0, 32'h00CA9210, 6, 3'b100, 1'b0);
        run_instr("andi",  7'b0010011, 3'b111, 1'b1, 1'b0, 32'h00CA9210, 6, 3'b011, 1'b0);
        run_instr("ld",    7'b0000011, 3'b011, 1'b0, 1'b0, 32'hC6543210, 8, 3'b000, 1'b0);
        run_instr("sd",    7'b0100011, 3'b011, 1'b0, 1'b0, 32'h00C73210, 6, 3'b000, 1'b0);
        run_instr("beq_t", 7'b1100011, 3'b000, 1'b0, 1'b1, 32'h0000B210, 4, 3'b000, 1'b1);
        run_instr("beq_n", 7'b1100011, 3'b000, 1'b0, 1'b0, 32'h000CB210, 5, 3'b000, 1'b0);
        run_instr("bne_t", 7'b1100011, 3'b001, 1'b0, 1'b0, 32'h0000B210, 4, 3'b000, 1'b1);
        run_instr("bne_n", 7'b1100011, 3'b001, 1'b0, 1'b1, 32'h000CB210, 5, 3'b000, 1'b0);

        run_halt("halt_op",  7'b1111111, 3'b000, 1'b0);
        run_halt("halt_r",   7'b0110011, 3'b010, 1'b0);
        run_halt("halt_i",   7'b0010011, 3'b001, 1'b0);
        run_halt("halt_ld",  7'b0000011, 3'b010, 1'b0);
        run_halt("halt_br",  7'b1100011, 3'b100, 1'b0);

        // Reset asserted while the store is in SD_WRITE.
        set_ir(7'b0100011, 3'b011, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        #1;
        chk("sdrst_st7", {28'd0, bus.state_out}, 32'd7);
        chk("sdrst_mw_pre", {31'd0, bus.MemData_Write}, 32'd1);
        rst = 1'b1; #1;
        chk("sdrst_mw", {31'd0, bus.MemData_Write}, 32'd0);
        chk("sdrst_ctl", cur_ctl(), 32'd0);
        @(negedge clk); #1;
        rst = 1'b0; #1;
        chk("sdrst_st0", {28'd0, bus.state_out}, 32'd0);
        run_instr("add_resume", 7'b0110011, 3'b000, 1'b0, 1'b0, 32'h00CA8210, 6, 3'b001, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
